// File: rtl/store_unit.sv
// S-type store unit (SB/SH/SW): computes rs1 + sext(imm) and streams rs2 into an
// 8-bit single-port RAM one byte per cycle, little-endian, with an en/done handshake.
module store_unit #(
  parameter int XPRLEN = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        funct3,
  input  logic [XPRLEN-1:0] rs1_value,
  input  logic [XPRLEN-1:0] rs2_value,
  input  logic [6:0]        imm_hi,
  input  logic [4:0]        imm_lo,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes_q;
  logic [XPRLEN-9:0] data_q;

  logic [XPRLEN-1:0] imm_sext;
  logic [XPRLEN-1:0] ea_next;
  logic [2:0]        nbytes;
  logic              legal;
  logic              unused_ea_bits;

  assign imm_sext = {{(XPRLEN-12){imm_hi[6]}}, imm_hi, imm_lo};
  assign ea_next  = rs1_value + imm_sext;
  // Only the RAM-address bits and the alignment bits of the effective address matter.
  assign unused_ea_bits = &{1'b0, ea_next[XPRLEN-1:ADDR_W]};

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    nbytes = 3'd0;
    legal  = 1'b0;
    case (funct3)
      3'b000: begin nbytes = 3'd1; legal = 1'b1;                end
      3'b001: begin nbytes = 3'd2; legal = ~ea_next[0];         end
      3'b010: begin nbytes = 3'd4; legal = (ea_next[1:0] == 2'b00); end
      default: begin nbytes = 3'd0; legal = 1'b0;               end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      nbytes_q    <= 3'd0;
      data_q      <= '0;
      ram_address <= '0;
      ram_data    <= 8'h00;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        // The edge that ends the DONE cycle may already accept the next store.
        IDLE, DONE: begin
          if (en) begin
            if (legal) begin
              state       <= WRITE;
              cnt         <= 3'd1;
              nbytes_q    <= nbytes;
              data_q      <= rs2_value[XPRLEN-1:8];
              ram_address <= ea_next[ADDR_W-1:0];
              ram_data    <= rs2_value[7:0];
              ram_wren    <= 1'b1;
              busy        <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (cnt == nbytes_q) begin
            state    <= DONE;
            cnt      <= 3'd0;
            ram_wren <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            // Address wraps by natural truncation to ADDR_W bits.
            ram_address <= ram_address + 1'b1;
            ram_data    <= data_q[7:0];
            data_q      <= data_q >> 8;
            cnt         <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit with a behavioural 256-byte RAM
// and per-cycle checks of the write stream and the done/err handshake.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_value = '0;
  logic [31:0] rs2_value = '0;
  logic [6:0]  imm_hi = '0;
  logic [4:0]  imm_lo = '0;
  logic [7:0]  ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [7:0] mem [256];

  store_unit #(.XPRLEN(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .funct3(funct3),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .imm_hi(imm_hi), .imm_lo(imm_lo),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address] = ram_data;
      n_writes++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one store, then checks every cycle of its write stream and completion.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [11:0] imm, input int n, input logic [7:0] a0,
                           input logic exp_err, input string tag);
    logic [7:0]  a;
    logic [31:0] b;
    @(negedge clk);
    funct3 = f3; rs1_value = rs1; rs2_value = rs2;
    imm_hi = imm[11:5]; imm_lo = imm[4:0]; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int k = 1; k <= n; k++) begin
      a = a0 + 8'(k - 1);
      b = rs2 >> (8 * (k - 1));
      check({tag, " wren"}, {31'b0, ram_wren}, 32'd1);
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      check({tag, " done_early"}, {31'b0, done}, 32'd0);
      check({tag, " addr"}, {24'b0, ram_address}, {24'b0, a});
      check({tag, " data"}, {24'b0, ram_data}, {24'b0, b[7:0]});
      if (k < n) @(negedge clk);
    end
    if (n > 0) @(negedge clk);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, " wren_off"}, {31'b0, ram_wren}, 32'd0);
    check({tag, " busy_off"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int w0;
    int dones;
    int first_done_cyc;
    int second_wr_cyc;

    // Reset state
    @(negedge clk);
    check("rst addr", {24'b0, ram_address}, 32'h0);
    check("rst data", {24'b0, ram_data}, 32'h0);
    check("rst outs", {28'b0, ram_wren, busy, done, err}, 32'h0);
    rst_n = 1'b1;

    // SW 0x10+4
    run_store(3'b010, 32'h10, 32'h11223344, 12'd4, 4, 8'h14, 1'b0, "sw");
    check("ram 14", {24'b0, mem[8'h14]}, 32'h44);
    check("ram 15", {24'b0, mem[8'h15]}, 32'h33);
    check("ram 16", {24'b0, mem[8'h16]}, 32'h22);
    check("ram 17", {24'b0, mem[8'h17]}, 32'h11);

    // SB with imm = -1
    run_store(3'b000, 32'h20, 32'hDEADBEAB, 12'hFFF, 1, 8'h1F, 1'b0, "sb_neg");
    check("ram 1f", {24'b0, mem[8'h1F]}, 32'hAB);
    check("ram 20 untouched", {24'b0, mem[8'h20]}, 32'h00);

    // Truncation to ADDR_W bits, then SH over the top bytes
    run_store(3'b010, 32'h1FC, 32'hA1B2C3D4, 12'd0, 4, 8'hFC, 1'b0, "sw_wrap");
    check("ram ff", {24'b0, mem[8'hFF]}, 32'hA1);
    run_store(3'b001, 32'hFE, 32'h5566, 12'd0, 2, 8'hFE, 1'b0, "sh");
    check("ram fc", {24'b0, mem[8'hFC]}, 32'hD4);
    check("ram fd", {24'b0, mem[8'hFD]}, 32'hC3);
    check("ram fe", {24'b0, mem[8'hFE]}, 32'h66);
    check("ram ff2", {24'b0, mem[8'hFF]}, 32'h55);

    // Misaligned and illegal stores
    w0 = n_writes;
    run_store(3'b010, 32'h11, 32'hFFFFFFFF, 12'd0, 0, 8'h00, 1'b1, "sw_mis");
    run_store(3'b001, 32'h03, 32'hFFFFFFFF, 12'd0, 0, 8'h00, 1'b1, "sh_mis");
    run_store(3'b011, 32'h30, 32'hFFFFFFFF, 12'd0, 0, 8'h00, 1'b1, "illegal");
    check("no writes on err", n_writes, w0);
    check("ram 11", {24'b0, mem[8'h11]}, 32'h00);
    check("ram 03", {24'b0, mem[8'h03]}, 32'h00);

    // en held high; second request changes operands mid-store
    w0 = n_writes; dones = 0; first_done_cyc = -1; second_wr_cyc = -1;
    @(negedge clk);
    funct3 = 3'b010; rs1_value = 32'h50; rs2_value = 32'h01020304;
    imm_hi = 7'h00; imm_lo = 5'h00; en = 1'b1;
    @(negedge clk);
    funct3 = 3'b000; rs1_value = 32'h30; rs2_value = 32'h00000077;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        dones++;
        if (first_done_cyc < 0) first_done_cyc = c;
      end
      if (ram_wren && ram_address == 8'h30 && second_wr_cyc < 0) begin
        second_wr_cyc = c;
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
    check("b2b writes", n_writes - w0, 32'd5);
    check("b2b dones", dones, 32'd2);
    check("b2b order", {31'b0, (second_wr_cyc > first_done_cyc) && (first_done_cyc >= 0)}, 32'd1);
    check("ram 50", {24'b0, mem[8'h50]}, 32'h04);
    check("ram 53", {24'b0, mem[8'h53]}, 32'h01);
    check("ram 30", {24'b0, mem[8'h30]}, 32'h77);

    // Async reset after two bytes of a SW
    @(negedge clk);
    funct3 = 3'b010; rs1_value = 32'h60; rs2_value = 32'hCAFEBABE;
    imm_hi = 7'h00; imm_lo = 5'h00; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst addr", {24'b0, ram_address}, 32'h0);
    check("arst data", {24'b0, ram_data}, 32'h0);
    check("arst outs", {28'b0, ram_wren, busy, done, err}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst no done", {31'b0, done}, 32'd0);
    end
    check("ram 60", {24'b0, mem[8'h60]}, 32'hBE);
    check("ram 61", {24'b0, mem[8'h61]}, 32'hBA);
    check("ram 62", {24'b0, mem[8'h62]}, 32'h00);
    rst_n = 1'b1;
    run_store(3'b000, 32'h40, 32'h0000005A, 12'd0, 1, 8'h40, 1'b0, "sb_after_rst");
    check("ram 40", {24'b0, mem[8'h40]}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-write counterpart of the load-byte unit in the mini RISC-V core; executes S-type stores SB/SH/SW.
- Computes effective address rs1 + sext(imm), then writes the rs2 value one byte per cycle, little-endian, into the 8-bit-wide single-port RAM (address/data/wren).
- Shares the en/done handshake style of the load unit so the core's execute stage can sequence both identically.

Parameters:
XPRLEN, 32, register/data width.
ADDR_W, 8, RAM address width; effective address truncated to ADDR_W LSBs.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  start request; sampled only in IDLE.
funct3  input  3  store size: 3'b000 SB, 3'b001 SH, 3'b010 SW; others illegal.
rs1_value  input  XPRLEN  base address value (register contents, not index).
rs2_value  input  XPRLEN  store data value (register contents, not index).
imm_hi  input  7  imm[11:5] of S-type encoding.
imm_lo  input  5  imm[4:0] of S-type encoding.
ram_address  output  ADDR_W  RAM byte address, registered.
ram_data  output  8  RAM write data, registered.
ram_wren  output  1  RAM write enable, registered.
busy  output  1  high while bytes are being written.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle pulse coincident with done on misaligned or illegal store.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0, err=0, byte counter=0. Takes effect immediately, mid-operation included; no done is issued for an interrupted store; bytes already written stay written.
- States: IDLE, WRITE, DONE.
- IDLE: en=1 at edge T -> capture funct3, rs2_value, ea = rs1_value + sign_extend({imm_hi,imm_lo}) (XPRLEN-bit, mod 2^XPRLEN). Operand changes after T are ignored.
- Byte count n: SB=1, SH=2, SW=4.
- Legality check at T:
  - Illegal funct3, SH with ea[0]=1, or SW with ea[1:0]!=0 -> go to DONE.
  - done=1 and err=1 in cycle T+1.
  - ram_wren never asserts.
- Legal -> WRITE; ram_wren=1 in cycles T+1..T+n.
  - In cycle T+k (k=1..n): ram_address = (ea + k-1) mod 2^ADDR_W; ram_data = rs2_value[8(k-1)+7 : 8(k-1)].
  - busy=1 in cycles T+1..T+n.
- DONE: done=1 for exactly one cycle (T+n+1; T+1 on error); busy=0, ram_wren=0; then return to IDLE.
- en is ignored in WRITE and DONE; the earliest next accept is the edge ending the DONE cycle, so back-to-back stores have one idle gap.
- Outside WRITE: ram_wren=0; ram_address/ram_data hold their last values.
- Address wrap: low-ADDR_W wrap is natural truncation; alignment is checked on full ea.

Test Plan:
- SW, rs1=0x10, imm=+4, rs2=0x11223344, en at T -> wren at T+1..T+4 writing 0x14:44, 0x15:33, 0x16:22, 0x17:11; busy T+1..T+4; done at T+5, err=0; RAM readback matches.
- SB negative offset, rs1=0x20, imm_hi=7'h7F, imm_lo=5'h1F (imm=-1), rs2=0xDEADBEAB -> single write at T+1, addr 0x1F, data 0xAB; done at T+2.
- SW, rs1=0x1FC, imm=0, rs2=0xA1B2C3D4 -> addresses 0xFC..0xFF with data D4, C3, B2, A1 (ADDR_W truncation); also SH at rs1=0xFE, rs2=0x5566 -> 0xFE:66, 0xFF:55.
- Misaligned/illegal: SW rs1=0x11, SH rs1=0x03, funct3=3'b011 -> each gives done=err=1 at T+1, wren never high, RAM unchanged.
- en held high continuously with a second SB request during the first SW -> second request accepted only after the first done; exactly 4+1 writes total, two done pulses.
- Async reset: assert rst_n=0 after 2 bytes of a SW -> all outputs 0 immediately, no done; after release, an SB to 0x40 completes normally in 2 cycles.
